// File: rtl/nettlp_frame_gen.sv
// nettlp_frame_gen: builds one Ethernet/IPv4/UDP NetTLP frame per accepted start.
//   The frame carries a 4DW MWr TLP with an incrementing payload.
// Latency: the first beat is valid 2 cycles after the accepted start (one CALC cycle, then HDR).
// Backpressure: the beat is held stable while m_axis_tready is low. tvalid never drops mid-frame.
// Ports:
//   clk156/sys_rst   clock, async active-high reset
//   start + request  len_dw, addr, tag, seed, MACs and IPs are sampled with start in IDLE
//   m_axis_*         64-bit AXI-Stream master; byte lane 0 is the first wire byte
//   busy/err_len     not-IDLE flag; one-cycle pulse on a rejected length
//   seq_num          sequence number of the next frame
module nettlp_frame_gen #(
  parameter int          MAX_LEN_DW   = 256,
  parameter logic [15:0] UDP_DST_PORT = 16'h3000
) (
  input  logic        clk156,
  input  logic        sys_rst,
  input  logic        start,
  input  logic [9:0]  len_dw,
  input  logic [63:0] addr,
  input  logic [7:0]  tag,
  input  logic [31:0] seed,
  input  logic [47:0] dst_mac,
  input  logic [47:0] src_mac,
  input  logic [31:0] src_ip,
  input  logic [31:0] dst_ip,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        busy,
  output logic        err_len,
  output logic [15:0] seq_num
);

  typedef enum logic [1:0] {IDLE, CALC, HDR, PAY} state_t;

  localparam logic [10:0] MAX_LEN = 11'(MAX_LEN_DW);

  state_t state_q, state_d;

  logic [31:0]  ts_q;
  logic [15:0]  seq_q;
  logic         err_q;
  logic [9:0]   len_q;
  logic [63:0]  addr_q;
  logic [7:0]   tag_q;
  logic [31:0]  seed_q;
  logic [47:0]  dst_mac_q, src_mac_q;
  logic [31:0]  src_ip_q, dst_ip_q, ts_lat_q;
  logic [511:0] hdr_q;      // byte n of the header lives at [8n+7:8n]
  logic [2:0]   beat_q;
  logic [9:0]   pay_left_q; // payload beats still to send, including the current one
  logic [31:0]  pay_dw_q;   // value of the DW in lanes 0..3 of the current payload beat

  logic         len_ok;
  logic         fire;
  logic         pay_last;
  logic [15:0]  ip_len, udp_len, udp_dst, csum;
  logic [31:0]  csum_sum;
  logic [16:0]  csum_f1, csum_f2;
  logic [511:0] hdr_be, hdr_le;
  logic [31:0]  dw_lo, dw_hi;

  assign len_ok   = (len_dw != 10'd0) && ({1'b0, len_dw} <= MAX_LEN);
  assign fire     = m_axis_tvalid && m_axis_tready;
  assign pay_last = (pay_left_q == 10'd1);
  assign busy     = (state_q != IDLE);
  assign err_len  = err_q;
  assign seq_num  = seq_q;

  // Header fields, evaluated from the latched request during CALC.
  assign ip_len  = 16'd50 + {4'd0, len_q, 2'b00};
  assign udp_len = 16'd30 + {4'd0, len_q, 2'b00};
  assign udp_dst = UDP_DST_PORT + {12'd0, tag_q[3:0]};

  // IP checksum over the ten header words with the checksum word as 0.
  // Ten 16-bit words cannot overflow 20 bits, so two folds are enough.
  assign csum_sum = 32'h4500 + {16'd0, ip_len} + {16'd0, seq_q} + 32'h4000 + 32'h4011
                  + {16'd0, src_ip_q[31:16]} + {16'd0, src_ip_q[15:0]}
                  + {16'd0, dst_ip_q[31:16]} + {16'd0, dst_ip_q[15:0]};
  assign csum_f1  = {1'b0, csum_sum[15:0]} + {1'b0, csum_sum[31:16]};
  assign csum_f2  = {1'b0, csum_f1[15:0]} + {16'd0, csum_f1[16]};
  assign csum     = ~csum_f2[15:0];

  // Header in wire order, first byte at the MSB.
  assign hdr_be = {dst_mac_q, src_mac_q, 16'h0800,
                   8'h45, 8'h00, ip_len, seq_q, 16'h4000, 8'd64, 8'd17, csum,
                   src_ip_q, dst_ip_q,
                   16'h3000, udp_dst, udp_len, 16'h0000,
                   seq_q, ts_lat_q,
                   32'h6000_0000 | {22'd0, len_q}, {16'h0000, tag_q, 8'hFF},
                   addr_q[63:32], addr_q[31:0]};

  // Reverse bytes so beat b is simply hdr_q[64b +: 64] with lane 0 first.
  always_comb begin
    hdr_le = '0;
    for (int n = 0; n < 64; n++) begin
      hdr_le[8*n +: 8] = hdr_be[511-8*n -: 8];
    end
  end

  assign dw_lo = pay_dw_q;
  assign dw_hi = pay_dw_q + 32'd1;

  always_ff @(posedge clk156 or posedge sys_rst) begin
    if (sys_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    case (state_q)
      IDLE: if (start && len_ok) state_d = CALC;
      CALC: state_d = HDR;
      HDR: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = hdr_q[{beat_q, 6'd0} +: 64];
        m_axis_tkeep  = 8'hFF;
        if (fire && beat_q == 3'd7) state_d = PAY;
      end
      PAY: begin
        m_axis_tvalid      = 1'b1;
        m_axis_tlast       = pay_last;
        m_axis_tdata[31:0] = {dw_lo[7:0], dw_lo[15:8], dw_lo[23:16], dw_lo[31:24]};
        // An odd length leaves the upper half of the final beat empty.
        if (pay_last && len_q[0]) begin
          m_axis_tkeep = 8'h0F;
        end else begin
          m_axis_tkeep        = 8'hFF;
          m_axis_tdata[63:32] = {dw_hi[7:0], dw_hi[15:8], dw_hi[23:16], dw_hi[31:24]};
        end
        if (fire && pay_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk156 or posedge sys_rst) begin
    if (sys_rst) begin
      ts_q       <= '0;
      seq_q      <= '0;
      err_q      <= 1'b0;
      len_q      <= '0;
      addr_q     <= '0;
      tag_q      <= '0;
      seed_q     <= '0;
      dst_mac_q  <= '0;
      src_mac_q  <= '0;
      src_ip_q   <= '0;
      dst_ip_q   <= '0;
      ts_lat_q   <= '0;
      hdr_q      <= '0;
      beat_q     <= '0;
      pay_left_q <= '0;
      pay_dw_q   <= '0;
    end else begin
      ts_q  <= ts_q + 32'd1;
      err_q <= (state_q == IDLE) && start && !len_ok;
      case (state_q)
        IDLE: if (start && len_ok) begin
          len_q     <= len_dw;
          addr_q    <= addr;
          tag_q     <= tag;
          seed_q    <= seed;
          dst_mac_q <= dst_mac;
          src_mac_q <= src_mac;
          src_ip_q  <= src_ip;
          dst_ip_q  <= dst_ip;
          ts_lat_q  <= ts_q;
        end
        CALC: begin
          hdr_q      <= hdr_le;
          beat_q     <= 3'd0;
          pay_left_q <= 10'(({1'b0, len_q} + 11'd1) >> 1);
          pay_dw_q   <= seed_q;
        end
        HDR: if (fire) beat_q <= beat_q + 3'd1;
        PAY: if (fire) begin
          pay_dw_q   <= pay_dw_q + 32'd2;
          pay_left_q <= pay_left_q - 10'd1;
          if (pay_last) seq_q <= seq_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nettlp_frame_gen.sv
// tb_nettlp_frame_gen: directed frames against hand-computed header/payload bytes.
// Latency: n/a.
// Backpressure: drives tready constant-high or random per test.
module tb_nettlp_frame_gen;

  logic        clk156 = 1'b0;
  logic        sys_rst;
  logic        start;
  logic [9:0]  len_dw;
  logic [63:0] addr;
  logic [7:0]  tag;
  logic [31:0] seed;
  logic [47:0] dst_mac, src_mac;
  logic [31:0] src_ip, dst_ip;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic        busy, err_len;
  logic [15:0] seq_num;

  nettlp_frame_gen #(.MAX_LEN_DW(256), .UDP_DST_PORT(16'h3000)) dut (
    .clk156(clk156), .sys_rst(sys_rst), .start(start), .len_dw(len_dw), .addr(addr),
    .tag(tag), .seed(seed), .dst_mac(dst_mac), .src_mac(src_mac), .src_ip(src_ip),
    .dst_ip(dst_ip), .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .busy(busy), .err_len(err_len), .seq_num(seq_num)
  );

  always #5 clk156 = ~clk156;

  int total = 0;
  int bad   = 0;

  logic [7:0]  rx[$];
  logic [7:0]  ref_rx[$];
  int          nb;
  int          first_cyc;
  int          err_seen;
  logic [63:0] last_d;
  logic [7:0]  last_k;

  task automatic check(input string tag_s, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag_s, got, exp);
    end
  endtask

  function automatic logic [15:0] be16(input int i);
    return {rx[i], rx[i+1]};
  endfunction

  function automatic logic [31:0] be32(input int i);
    return {rx[i], rx[i+1], rx[i+2], rx[i+3]};
  endfunction

  function automatic logic [15:0] ip_csum(input logic [15:0] tl, input logic [15:0] id,
                                          input logic [31:0] s, input logic [31:0] d);
    logic [31:0] sum;
    sum = 32'h4500 + 32'(tl) + 32'(id) + 32'h4000 + 32'h4011
        + 32'(s[31:16]) + 32'(s[15:0]) + 32'(d[31:16]) + 32'(d[15:0]);
    while (sum[31:16] != 16'd0) sum = 32'(sum[15:0]) + 32'(sum[31:16]);
    return ~sum[15:0];
  endfunction

  task automatic do_reset();
    @(negedge clk156); sys_rst = 1'b1;
    @(negedge clk156); sys_rst = 1'b0;
    repeat (4) @(negedge clk156);
  endtask

  task automatic send(input logic [9:0] l, input logic [31:0] sd, input logic [63:0] a,
                      input logic [7:0] tg);
    @(negedge clk156);
    len_dw = l; seed = sd; addr = a; tag = tg; start = 1'b1;
    @(negedge clk156);
    start = 1'b0;
  endtask

  // Collects one frame; returns at the negedge where the tlast beat is presented.
  task automatic collect(input bit rnd, input bit hold_start);
    logic [63:0] hd;
    logic [7:0]  hk;
    logic        hl;
    bit          stalled = 0;
    bit          done = 0;
    bit          begun = 0;
    int          cyc = 0;
    rx.delete();
    nb = 0; first_cyc = -1; err_seen = 0;
    while (!done && cyc < 3000) begin
      @(negedge clk156);
      cyc++;
      m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = hold_start;
      #1;
      if (err_len) err_seen++;
      if (begun) check("vld_gap", m_axis_tvalid, 1'b1);
      if (stalled) begin
        check("hold_dat", m_axis_tdata, hd);
        check("hold_keep", m_axis_tkeep, hk);
        check("hold_last", m_axis_tlast, hl);
        stalled = 0;
      end
      if (m_axis_tvalid) begin
        if (!begun) first_cyc = cyc;
        begun = 1;
        if (m_axis_tready) begin
          for (int i = 0; i < 8; i++) rx.push_back(m_axis_tdata[8*i +: 8]);
          nb++;
          last_d = m_axis_tdata;
          last_k = m_axis_tkeep;
          if (m_axis_tlast) done = 1;
        end else begin
          stalled = 1;
          hd = m_axis_tdata; hk = m_axis_tkeep; hl = m_axis_tlast;
        end
      end
    end
    start = 1'b0;
    if (!done) check("frame_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int errs, vlds, diff, seen;
    bit hit;
    sys_rst = 1'b1; start = 1'b0; len_dw = '0; addr = '0; tag = '0; seed = '0;
    dst_mac = 48'h0211_2233_4455; src_mac = 48'h0266_7788_99AA;
    src_ip = 32'hC0A8_0A01; dst_ip = 32'hC0A8_0A03;
    m_axis_tready = 1'b1;
    repeat (3) @(negedge clk156);
    #1;
    check("rst_vld", m_axis_tvalid, 1'b0);
    check("rst_last", m_axis_tlast, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err_len, 1'b0);
    check("rst_dat", m_axis_tdata, 64'd0);
    check("rst_keep", m_axis_tkeep, 8'd0);
    check("rst_seq", seq_num, 16'd0);
    @(negedge clk156); sys_rst = 1'b0;
    repeat (2) @(negedge clk156);

    // len 1: header fields and an odd final beat; start held high while busy is ignored
    send(10'd1, 32'hA5A5_0000, 64'h0000_0001_2345_6780, 8'h5A);
    #1;
    check("calc_vld", m_axis_tvalid, 1'b0);
    check("calc_busy", busy, 1'b1);
    collect(1'b0, 1'b1);
    check("t1_lat", first_cyc, 1);
    check("t1_beats", nb, 9);
    check("t1_last_dat", last_d, 64'h0000_0000_0000_A5A5);
    check("t1_last_keep", last_k, 8'h0F);
    check("t1_busy_err", err_seen, 0);
    check("t1_dmac", {be32(0), be16(4)}, 48'h0211_2233_4455);
    check("t1_etype", be16(12), 16'h0800);
    check("t1_vihl", rx[14], 8'h45);
    check("t1_iplen", be16(16), 16'd54);
    check("t1_ipid", be16(18), 16'd0);
    check("t1_ttlproto", be16(22), 16'h4011);
    check("t1_csum", be16(24), 16'hA562);
    check("t1_dip", be32(30), 32'hC0A8_0A03);
    check("t1_sport", be16(34), 16'h3000);
    check("t1_dport", be16(36), 16'h300A);
    check("t1_udplen", be16(38), 16'd34);
    check("t1_ntseq", be16(42), 16'd0);
    check("t1_dw0", be32(48), 32'h6000_0001);
    check("t1_dw1", be32(52), 32'h0000_5AFF);
    check("t1_dw2", be32(56), 32'h0000_0001);
    check("t1_dw3", be32(60), 32'h2345_6780);
    @(negedge clk156); #1;
    check("t1_seqnum", seq_num, 16'd1);
    check("t1_idle", busy, 1'b0);

    // len 4: payload wraps through zero
    send(10'd4, 32'hFFFF_FFFE, 64'h0000_0000_0000_1000, 8'h03);
    collect(1'b0, 1'b0);
    check("t2_beats", nb, 10);
    check("t2_last_keep", last_k, 8'hFF);
    check("t2_p0", be32(64), 32'hFFFF_FFFE);
    check("t2_p1", be32(68), 32'hFFFF_FFFF);
    check("t2_p2", be32(72), 32'h0000_0000);
    check("t2_p3", be32(76), 32'h0000_0001);
    check("t2_iplen", be16(16), 16'd66);
    check("t2_udplen", be16(38), 16'd46);
    check("t2_csum", be16(24), ip_csum(16'd66, 16'd1, src_ip, dst_ip));
    check("t2_ntseq", be16(42), 16'd1);
    check("t2_dport", be16(36), 16'h3003);
    @(negedge clk156);

    // rejected lengths
    for (int k = 0; k < 2; k++) begin
      errs = 0; vlds = 0;
      @(negedge clk156);
      len_dw = (k == 0) ? 10'd0 : 10'd257; start = 1'b1;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk156); start = 1'b0; #1;
        if (err_len) errs++;
        if (m_axis_tvalid) vlds++;
      end
      check("err_pulses", errs, 1);
      check("err_novld", vlds, 0);
    end
    check("err_seq", seq_num, 16'd2);

    // three back-to-back frames after reset
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(10'(2 + i), 32'h1000_0000 * (i + 1), 64'h0000_0000_0000_2000, 8'(i));
      collect(1'b0, 1'b0);
      check("b2b_beats", nb, 8 + (2 + i + 1) / 2);
      check("b2b_seq", be16(42), 16'(i));
      check("b2b_csum", be16(24), ip_csum(16'(50 + 4 * (2 + i)), 16'(i), src_ip, dst_ip));
    end
    @(negedge clk156); #1;
    check("b2b_seqnum", seq_num, 16'd3);

    // reset while beat 3 is presented
    send(10'd3, 32'h0, 64'h0, 8'h00);
    seen = 0; hit = 0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk156); #1;
      if (m_axis_tvalid) begin
        if (seen == 3) begin
          sys_rst = 1'b1; #1;
          check("mid_vld", m_axis_tvalid, 1'b0);
          check("mid_busy", busy, 1'b0);
          check("mid_seq", seq_num, 16'd0);
          check("mid_dat", m_axis_tdata, 64'd0);
          hit = 1;
        end
        seen++;
      end
    end
    check("mid_hit", hit, 1'b1);
    @(negedge clk156); sys_rst = 1'b0;
    send(10'd1, 32'h0BAD_F00D, 64'h0, 8'h00);
    collect(1'b0, 1'b0);
    check("post_beats", nb, 9);
    check("post_seq", be16(42), 16'd0);
    check("post_pay", be32(64), 32'h0BAD_F00D);

    // max length, tready=1 versus random tready from the same reset point
    do_reset();
    send(10'd256, 32'h1234_5678, 64'hAAAA_0000_0000_0040, 8'h0F);
    collect(1'b0, 1'b0);
    check("max_beats", nb, 136);
    check("max_lastdw", be32(64 + 4 * 255), 32'h1234_5777);
    ref_rx = rx;
    do_reset();
    send(10'd256, 32'h1234_5678, 64'hAAAA_0000_0000_0040, 8'h0F);
    collect(1'b1, 1'b0);
    m_axis_tready = 1'b1;
    check("rnd_beats", nb, 136);
    diff = 0;
    for (int i = 0; i < ref_rx.size() && i < rx.size(); i++) if (rx[i] !== ref_rx[i]) diff++;
    check("rnd_stream", diff, 0);

    repeat (2) @(negedge clk156);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nettlp_frame_gen.md
Name: nettlp_frame_gen

Overview:
- Synthesizable NetTLP frame source for the QSFP RX side of the adapter; in simulation it drives the lanes the board bench ties low.
- Builds one Ethernet/IPv4/UDP frame per start: 6-byte NetTLP header plus a 4DW Memory Write TLP with incrementing payload.
- Emits the frame on a 64-bit AXI-Stream master toward the MAC RX path or a loopback mux.

Parameters:
- MAX_LEN_DW, 256, largest accepted payload length in DW; legal range 1..1023.
- UDP_DST_PORT, 16'h3000, base UDP destination port; the frame uses UDP_DST_PORT + tag[3:0].

Ports:
- clk156  input  1  stream and logic clock.
- sys_rst  input  1  asynchronous active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- len_dw  input  10  payload length in DW, sampled with start.
- addr  input  64  TLP address, 4-byte aligned, sampled with start.
- tag  input  8  TLP tag, sampled with start.
- seed  input  32  value of payload DW 0, sampled with start.
- dst_mac / src_mac  input  48 each  Ethernet addresses, sampled with start.
- src_ip / dst_ip  input  32 each  IPv4 addresses, sampled with start.
- m_axis_tdata  output  64  byte lane 0 is the first wire byte.
- m_axis_tkeep  output  8  byte enables.
- m_axis_tvalid  output  1  beat valid.
- m_axis_tready  input  1  sink ready.
- m_axis_tlast  output  1  last beat of frame.
- busy  output  1  high whenever the state is not IDLE.
- err_len  output  1  one-cycle pulse when a request is rejected.
- seq_num  output  16  sequence number of the next frame.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Clock port is clk156, reset port is sys_rst.
- Reset values: tvalid, tlast, busy, err_len = 0; tdata and tkeep = 0; seq_num = 0; timestamp counter = 0; state = IDLE.
- Timestamp counter: 32-bit free-running, +1 per cycle, wraps at 2^32.
- States and transitions:
  - IDLE: on start with 1 <= len_dw <= MAX_LEN_DW, latch all inputs and the timestamp, then go to CALC.
  - IDLE, rejected request: on start with len_dw = 0 or len_dw > MAX_LEN_DW, pulse err_len for 1 cycle and stay in IDLE.
  - CALC: for 1 cycle, compute lengths and the IP checksum, load the 64-byte header register, then go to HDR.
  - HDR: 8 beats of header.
  - PAY: ceil(len_dw/2) beats of payload, then back to IDLE.
- Latency: first tvalid in the 2nd cycle after the accepted start.
- Header byte order (64 B total):
  - Ethernet: dst_mac, src_mac, type 0x0800.
  - IPv4: 0x45, 0x00, total length, id = seq, flags/frag 0x4000, TTL 64, protocol 17, checksum, src_ip, dst_ip.
  - UDP: src port 0x3000, dst port UDP_DST_PORT + tag[3:0], length, checksum 0.
  - NetTLP: seq(16), timestamp(32).
  - TLP: DW0 = 0x60000000 | len_dw (fmt 4DW with data, MWr; length field = len_dw); DW1 = {16'h0000, tag, 8'hFF}; DW2 = addr[63:32]; DW3 = addr[31:0].
  - All multi-byte fields are big-endian.
- Lengths:
  - IP total length = 50 + 4*len_dw.
  - UDP length = 30 + 4*len_dw.
  - Both 16-bit.
- IP checksum: one's-complement of the end-around-carry sum of the ten header 16-bit words, with the checksum field taken as 0.
- Payload: DW k = seed + k, modulo 2^32, big-endian on the wire.
- Last beat tkeep:
  - odd len_dw: tkeep = 8'h0F; unused upper lanes are 0.
  - even len_dw: tkeep = 8'hFF.
  - All other beats: tkeep = 8'hFF.
- Handshake:
  - A beat transfers when tvalid && tready.
  - tdata, tkeep and tlast are held stable while tvalid && !tready.
  - tvalid never drops mid-frame.
- Sequence number: seq_num increments (wrapping at 16 bits) on the tlast transfer. The frame carries the value held before the increment.
- Simultaneous events:
  - start is ignored while busy, with no err_len pulse.
  - A new start is accepted in the cycle after the tlast transfer, so frames run back to back with one CALC gap cycle.
- Reset mid-frame: the frame is abandoned, all outputs return to reset values, and seq_num returns to 0.

Test Plan:
- len_dw=1, seed=0xA5A5_0000, tready=1 -> 9 beats; beat 8 tdata bytes A5 A5 00 00, tkeep 0x0F, tlast=1; IP length 54, UDP length 34.
- len_dw=4, seed=0xFFFF_FFFE -> payload DWs FFFFFFFE, FFFFFFFF, 00000000, 00000001; 10 beats; last tkeep 0xFF.
- Random tready (50%) with len_dw=MAX_LEN_DW -> data held while stalled; 136 beats; output byte stream identical to the tready=1 run.
- len_dw=0, then len_dw=MAX_LEN_DW+1 -> err_len pulses once each; no tvalid; seq_num unchanged.
- Three back-to-back frames -> NetTLP seq 0,1,2; seq_num=3 at the end; IP checksum matches the reference model for src 192.168.10.1, dst 192.168.10.3.
- Assert sys_rst during beat 3 -> tvalid=0 immediately; seq_num=0; the next start produces a full frame with seq 0.
